// File: rtl/spi_req_sequencer.sv
// Arbitrates NREQ frame requesters onto one SPI master and returns the shift-in word, with a watchdog abort.
// Define SPI_SEQ_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module spi_req_sequencer #(
  parameter int WIDTH    = 24,
  parameter int NREQ     = 4,
  parameter int TO_W     = 8,
  parameter int READ_BIT = 23
) (
  input  logic                  n_rst,
  input  logic                  sclk,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  rsp_valid_o,
  output logic [2:0]            rsp_id_o,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic                  rsp_err_o,
  output logic [WIDTH-1:0]      spi_in_data_o,
  output logic                  spi_in_ena_o,
  input  logic                  spi_busy_i,
  input  logic [WIDTH-1:0]      spi_miso_reg_i,
  input  logic                  spi_miso_reg_ena_i,
  output logic                  active_o
);

  typedef enum logic [1:0] {IDLE, LOAD, XFER, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   reqReady_q, reqReady_d;
  logic              rspValid_q, rspValid_d;
  logic [2:0]        rspId_q, rspId_d;
  logic [WIDTH-1:0]  rspData_q, rspData_d;
  logic              rspErr_q, rspErr_d;
  logic [WIDTH-1:0]  spiInData_q, spiInData_d;
  logic              spiInEna_q, spiInEna_d;
  logic              isRead_q, isRead_d;
  logic [TO_W-1:0]   wdCnt_q, wdCnt_d;

  logic [2:0]        grantIdx;
  logic              grantFound;
  logic [WIDTH-1:0]  grantData;
  logic              timeout;

  assign grantData = req_data_i[int'(grantIdx)*WIDTH +: WIDTH];
  assign timeout   = (wdCnt_q == {TO_W{1'b1}});

`ifdef SPI_SEQ_FIXED_PRIO_EN
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = 3'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        grantFound = 1'b1;
        grantIdx   = 3'(i);
      end
    end
  end
`else
  logic [2:0] lastGrant_q, lastGrant_d;
  logic       releaseGrant;
  int         rrIdx;

  // Scan from farthest to nearest so the nearest requester after the last grant wins.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = 3'd0;
    rrIdx      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      rrIdx = int'(lastGrant_q) + k;
      if (rrIdx >= NREQ) rrIdx = rrIdx - NREQ;
      if (req_valid_i[rrIdx]) begin
        grantFound = 1'b1;
        grantIdx   = 3'(rrIdx);
      end
    end
  end

  assign releaseGrant = (state_q != IDLE) && (state_d == IDLE);
  assign lastGrant_d  = releaseGrant ? rspId_q : lastGrant_q;

  always_ff @(posedge sclk or negedge n_rst) begin
    if (!n_rst) lastGrant_q <= 3'(NREQ - 1);
    else        lastGrant_q <= lastGrant_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    reqReady_d  = '0;
    rspValid_d  = 1'b0;
    rspId_d     = rspId_q;
    rspData_d   = rspData_q;
    rspErr_d    = rspErr_q;
    spiInData_d = spiInData_q;
    spiInEna_d  = spiInEna_q;
    isRead_d    = isRead_q;
    wdCnt_d     = wdCnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        wdCnt_d = '0;
        if (grantFound && !spi_busy_i) begin
          reqReady_d  = {{(NREQ-1){1'b0}}, 1'b1} << grantIdx;
          spiInData_d = grantData;
          isRead_d    = grantData[READ_BIT];
          rspId_d     = grantIdx;
          spiInEna_d  = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (spi_busy_i) begin
          spiInEna_d = 1'b0;
          wdCnt_d    = '0;
          state_d    = XFER;
        end else if (timeout) begin
          spiInEna_d = 1'b0;
          rspValid_d = 1'b1;
          rspErr_d   = 1'b1;
          rspData_d  = '0;
          wdCnt_d    = '0;
          state_d    = IDLE;
        end
      end
      XFER: begin
        // A completing frame takes precedence over a watchdog expiry in the same cycle.
        if (spi_miso_reg_ena_i) begin
          rspValid_d = 1'b1;
          rspErr_d   = 1'b0;
          rspData_d  = isRead_q ? spi_miso_reg_i : '0;
          wdCnt_d    = '0;
          state_d    = DRAIN;
        end else if (timeout) begin
          spiInEna_d = 1'b0;
          rspValid_d = 1'b1;
          rspErr_d   = 1'b1;
          rspData_d  = '0;
          wdCnt_d    = '0;
          state_d    = IDLE;
        end
      end
      DRAIN: begin
        if (!spi_busy_i || timeout) begin
          spiInEna_d = 1'b0;
          wdCnt_d    = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      reqReady_q  <= '0;
      rspValid_q  <= 1'b0;
      rspId_q     <= 3'd0;
      rspData_q   <= '0;
      rspErr_q    <= 1'b0;
      spiInData_q <= '0;
      spiInEna_q  <= 1'b0;
      isRead_q    <= 1'b0;
      wdCnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      reqReady_q  <= reqReady_d;
      rspValid_q  <= rspValid_d;
      rspId_q     <= rspId_d;
      rspData_q   <= rspData_d;
      rspErr_q    <= rspErr_d;
      spiInData_q <= spiInData_d;
      spiInEna_q  <= spiInEna_d;
      isRead_q    <= isRead_d;
      wdCnt_q     <= wdCnt_d;
    end
  end

  assign req_ready_o   = reqReady_q;
  assign rsp_valid_o   = rspValid_q;
  assign rsp_id_o      = rspId_q;
  assign rsp_data_o    = rspData_q;
  assign rsp_err_o     = rspErr_q;
  assign spi_in_data_o = spiInData_q;
  assign spi_in_ena_o  = spiInEna_q;
  assign active_o      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_req_sequencer.sv
// Randomized self-checking bench for spi_req_sequencer: a per-cycle transaction model plus directed literal checks.
// Honours SPI_SEQ_FIXED_PRIO_EN for the expected arbitration order.
module tb_spi_req_sequencer;

  localparam int WIDTH    = 24;
  localparam int NREQ     = 4;
  localparam int TO_W     = 4;
  localparam int READ_BIT = 23;
  localparam int TMAX     = (1 << TO_W) - 1;

  logic                  n_rst;
  logic                  sclk;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [2:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
  logic [WIDTH-1:0]      spi_in_data;
  logic                  spi_in_ena;
  logic                  spi_busy;
  logic [WIDTH-1:0]      spi_miso_reg;
  logic                  spi_miso_reg_ena;
  logic                  active;

  spi_req_sequencer #(
    .WIDTH(WIDTH), .NREQ(NREQ), .TO_W(TO_W), .READ_BIT(READ_BIT)
  ) dut (
    .n_rst(n_rst),
    .sclk(sclk),
    .req_valid_i(req_valid),
    .req_data_i(req_data),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid),
    .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err),
    .spi_in_data_o(spi_in_data),
    .spi_in_ena_o(spi_in_ena),
    .spi_busy_i(spi_busy),
    .spi_miso_reg_i(spi_miso_reg),
    .spi_miso_reg_ena_i(spi_miso_reg_ena),
    .active_o(active)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int passCount  = 0;
  int checkCount = 0;
  int grantCount = 0;
  int rspCount   = 0;
  int grantQ[$];

  // The next requester to serve: lowest index, or the first valid one after the last grant going round.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    int idx;
    pick = -1;
`ifdef SPI_SEQ_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++)
      if (pick < 0 && v[k]) pick = k;
    idx = last;
`else
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (pick < 0 && v[idx]) pick = idx;
    end
`endif
  endfunction

  function automatic logic [WIDTH-1:0] randomCmd();
    logic [WIDTH-1:0] c;
    c = WIDTH'($urandom);
    c[READ_BIT] = ($urandom_range(1) == 1);
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Transaction-level reference: phase 0 waiting, 1 handing the command over, 2 frame running, 3 waiting for the master to go quiet.
  int               mPhase, mCnt, mLast, mPick;
  logic [NREQ-1:0]  eReady;
  logic             eRv, eErr, eIna, mRead;
  logic [2:0]       eId;
  logic [WIDTH-1:0] eData, eInd;

  always_comb mPick = pick(req_valid, mLast);

  always @(posedge sclk or negedge n_rst) begin
    if (!n_rst) begin
      mPhase <= 0; mCnt <= 0; mLast <= NREQ - 1;
      eReady <= '0; eRv <= 1'b0; eErr <= 1'b0; eIna <= 1'b0; mRead <= 1'b0;
      eId <= 3'd0; eData <= '0; eInd <= '0;
    end else begin
      eReady <= '0;
      eRv    <= 1'b0;
      if (mPhase == 0) begin
        if (mPick >= 0 && !spi_busy) begin
          eReady <= NREQ'(1 << mPick);
          eInd   <= req_data[mPick*WIDTH +: WIDTH];
          mRead  <= req_data[mPick*WIDTH + READ_BIT];
          eId    <= 3'(mPick);
          eIna   <= 1'b1;
          mPhase <= 1;
          mCnt   <= 0;
        end
      end else if (mPhase == 3) begin
        if (!spi_busy || mCnt == TMAX) begin
          mLast <= int'(eId); mPhase <= 0; eIna <= 1'b0;
        end else mCnt <= mCnt + 1;
      end else if (mPhase == 1 && spi_busy) begin
        eIna <= 1'b0; mPhase <= 2; mCnt <= 0;
      end else if (mPhase == 2 && spi_miso_reg_ena) begin
        eRv <= 1'b1; eErr <= 1'b0; eData <= mRead ? spi_miso_reg : '0;
        mPhase <= 3; mCnt <= 0;
      end else if (mCnt == TMAX) begin
        eIna <= 1'b0; eRv <= 1'b1; eErr <= 1'b1; eData <= '0;
        mPhase <= 0; mLast <= int'(eId);
      end else mCnt <= mCnt + 1;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge sclk) begin
    if (n_rst) begin
      checkOutput("req_ready", 32'(req_ready), 32'(eReady));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(eRv));
      if (eRv) begin
        checkOutput("rsp_id", 32'(rsp_id), 32'(eId));
        checkOutput("rsp_data", 32'(rsp_data), 32'(eData));
        checkOutput("rsp_err", 32'(rsp_err), 32'(eErr));
      end
      checkOutput("spi_in_ena", 32'(spi_in_ena), 32'(eIna));
      checkOutput("spi_in_data", 32'(spi_in_data), 32'(eInd));
      checkOutput("active", 32'(active), 32'(mPhase != 0));
    end
  end

  // Stimulus state: requesters and a behavioural SPI master.
  bit keepReq, randReq, mNoise, mHang, mFixOn;
  int mMode, mst, mk, mLen, mPause, mDelay;
  logic [WIDTH-1:0] mFix;

  task automatic masterStep();
    case (mst)
      0: begin
        spi_miso_reg_ena = 1'b0;
        if (spi_in_ena) begin
          if (mMode == 1 || (mHang && $urandom_range(15) == 0)) begin
            spi_busy = 1'b0; mst = 5;
          end else if (mMode == 2) begin
            spi_busy = 1'b1; mk = 0; mst = 4;
          end else begin
            mDelay = $urandom_range(2);
            mLen   = (mHang && $urandom_range(15) == 0) ? 40 : 1 + $urandom_range(5);
            mPause = (mHang && $urandom_range(15) == 0) ? 40 : $urandom_range(3);
            if (mDelay == 0) begin spi_busy = 1'b1; mst = 2; end
            else begin spi_busy = 1'b0; mst = 1; end
          end
        end else spi_busy = mNoise && ($urandom_range(3) == 0);
      end
      1: begin
        mDelay--;
        if (mDelay == 0) begin spi_busy = 1'b1; mst = 2; end
      end
      2: begin
        if (!active) begin spi_busy = 1'b0; mst = 0; end
        else begin
          mLen--;
          if (mLen == 0) begin
            spi_miso_reg_ena = 1'b1;
            spi_miso_reg = mFixOn ? mFix : WIDTH'($urandom);
            mst = 3;
          end
        end
      end
      3: begin
        spi_miso_reg_ena = 1'b0;
        if (mPause == 0 || !active) begin spi_busy = 1'b0; mst = 0; end
        else mPause--;
      end
      4: begin
        mk++;
        if (mk == 16) begin spi_miso_reg_ena = 1'b1; spi_miso_reg = mFix; end
        else if (mk == 17) begin spi_miso_reg_ena = 1'b0; spi_busy = 1'b0; mst = 0; end
      end
      default: begin
        spi_busy = 1'b0;
        if (!spi_in_ena) mst = 0;
      end
    endcase
  endtask

  task automatic tick();
    @(negedge sclk);
    if (n_rst) begin
      if (rsp_valid) rspCount++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          grantQ.push_back(i);
          grantCount++;
          if (keepReq) req_data[i*WIDTH +: WIDTH] = randomCmd();
          else req_valid[i] = 1'b0;
        end
      end
      if (randReq)
        for (int i = 0; i < NREQ; i++)
          if (!req_valid[i] && $urandom_range(3) == 0) begin
            req_valid[i] = 1'b1;
            req_data[i*WIDTH +: WIDTH] = randomCmd();
          end
      masterStep();
      if (!spi_miso_reg_ena) spi_miso_reg = WIDTH'($urandom);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] cmd);
    req_data[idx*WIDTH +: WIDTH] = cmd;
    req_valid[idx] = 1'b1;
  endtask

  task automatic waitReady(input string name, output int idx);
    int n = 0;
    idx = -1;
    tick();
    while (req_ready == '0 && n < 100) begin tick(); n++; end
    if (req_ready == '0) checkOutput({name, " grant wait"}, 32'd0, 32'd1);
    else for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
  endtask

  task automatic waitRsp(input string name, output int cycles);
    cycles = 1;
    tick();
    while (!rsp_valid && cycles < 100) begin tick(); cycles++; end
    if (!rsp_valid) checkOutput({name, " response wait"}, 32'd0, 32'd1);
  endtask

  task automatic waitIdle(input string name, input int limit);
    int n = 0;
    do begin tick(); n++; end while (active && n < limit);
    if (active) checkOutput({name, " idle wait"}, 32'd1, 32'd0);
  endtask

  task automatic resetDut();
    @(negedge sclk);
    n_rst = 1'b0;
    req_valid = '0; keepReq = 0; randReq = 0;
    spi_busy = 1'b0; spi_miso_reg_ena = 1'b0; mst = 0;
    repeat (2) @(negedge sclk);
    n_rst = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int idx, cyc, g0, r0;
    int expOrder[6];
    n_rst = 1'b0; req_valid = '0; req_data = '0;
    spi_busy = 1'b0; spi_miso_reg = '0; spi_miso_reg_ena = 1'b0;
    keepReq = 0; randReq = 0; mNoise = 0; mHang = 0; mFixOn = 0; mFix = '0;
    mMode = 0; mst = 0; mk = 0; mLen = 0; mPause = 0; mDelay = 0;
    repeat (3) @(negedge sclk);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset spi_in_data", 32'(spi_in_data), 32'd0);
    checkOutput("reset spi_in_ena", 32'(spi_in_ena), 32'd0);
    checkOutput("reset active", 32'(active), 32'd0);
    n_rst = 1'b1;

    $display("[TB] reset in the middle of LOAD");
    mMode = 1;
    applyStimulus(0, 24'h111111);
    waitReady("midload", idx);
    tick();
    checkOutput("midload spi_in_ena", 32'(spi_in_ena), 32'd1);
    @(posedge sclk);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("midload rst spi_in_ena", 32'(spi_in_ena), 32'd0);
    checkOutput("midload rst active", 32'(active), 32'd0);
    checkOutput("midload rst spi_in_data", 32'(spi_in_data), 32'd0);
    checkOutput("midload rst rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midload rst req_ready", 32'(req_ready), 32'd0);
    @(negedge sclk);
    req_valid = '0; mst = 0; spi_busy = 1'b0;
    n_rst = 1'b1;
    r0 = rspCount;
    repeat (20) tick();
    checkOutput("midload no response", 32'(rspCount - r0), 32'd0);

    $display("[TB] single write");
    mMode = 0; mFixOn = 1; mFix = 24'hABCDEF;
    applyStimulus(1, 24'h012345);
    waitReady("write", idx);
    checkOutput("write req_ready", 32'(req_ready), 32'h2);
    checkOutput("write spi_in_data", 32'(spi_in_data), 32'h012345);
    waitRsp("write", cyc);
    checkOutput("write rsp_id", 32'(rsp_id), 32'd1);
    checkOutput("write rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("write rsp_err", 32'(rsp_err), 32'd0);
    waitIdle("write", 50);

    $display("[TB] single read");
    mFix = 24'h0000A5;
    applyStimulus(2, 24'h800000);
    waitReady("read", idx);
    checkOutput("read req_ready", 32'(req_ready), 32'h4);
    waitRsp("read", cyc);
    checkOutput("read rsp_id", 32'(rsp_id), 32'd2);
    checkOutput("read rsp_data", 32'(rsp_data), 32'h0000A5);
    checkOutput("read rsp_err", 32'(rsp_err), 32'd0);
    waitIdle("read", 50);

    $display("[TB] all requesters continuously valid");
    resetDut();
    mMode = 0; mNoise = 1; mFixOn = 0; keepReq = 1;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, randomCmd());
    grantQ.delete(); g0 = grantCount; r0 = rspCount;
    for (int n = 0; n < 600 && grantQ.size() < 6; n++) tick();
`ifdef SPI_SEQ_FIXED_PRIO_EN
    expOrder = '{0, 0, 0, 0, 0, 0};
`else
    expOrder = '{0, 1, 2, 3, 0, 1};
`endif
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("rotation grant %0d", i), (i < grantQ.size()) ? 32'(grantQ[i]) : 32'hFFFF, 32'(expOrder[i]));
    keepReq = 0; req_valid = '0;
    waitIdle("rotation", 100);
    checkOutput("rotation one rsp per grant", 32'(rspCount - r0), 32'(grantCount - g0));

    $display("[TB] watchdog expiry in LOAD");
    resetDut();
    mNoise = 0; mMode = 1; keepReq = 1;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, randomCmd());
    waitReady("timeout", idx);
    checkOutput("timeout first grant", 32'(idx), 32'd0);
    waitRsp("timeout", cyc);
    checkOutput("timeout latency", 32'(cyc), 32'd16);
    checkOutput("timeout rsp_err", 32'(rsp_err), 32'd1);
    checkOutput("timeout rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("timeout rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("timeout spi_in_ena", 32'(spi_in_ena), 32'd0);
    checkOutput("timeout active", 32'(active), 32'd0);
    waitReady("timeout next", idx);
`ifdef SPI_SEQ_FIXED_PRIO_EN
    checkOutput("timeout next grant", 32'(idx), 32'd0);
`else
    checkOutput("timeout next grant", 32'(idx), 32'd1);
`endif
    keepReq = 0; req_valid = '0;
    waitIdle("timeout", 100);

    $display("[TB] end of frame together with watchdog expiry");
    resetDut();
    mMode = 2; mFix = 24'h5A5A5A;
    applyStimulus(3, 24'h8000C3);
    waitReady("race", idx);
    waitRsp("race", cyc);
    checkOutput("race rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("race rsp_data", 32'(rsp_data), 32'h5A5A5A);
    checkOutput("race rsp_id", 32'(rsp_id), 32'd3);
    checkOutput("race active", 32'(active), 32'd1);
    waitIdle("race", 50);

    $display("[TB] randomized traffic");
    resetDut();
    mMode = 0; mNoise = 1; mHang = 1; mFixOn = 0; randReq = 1;
    repeat (3000) tick();
    randReq = 0; req_valid = '0;
    waitIdle("random", 200);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/spi_req_sequencer.md
Name: spi_req_sequencer

Overview:
Round-robin arbiter and transaction sequencer placed in front of the SPI master register block. It accepts frame requests from NREQ independent requesters and grants them one at a time. For the granted request it drives the master's in_data/in_ena handshake, then waits for the frame to complete. It returns the captured shift-in word to the granted requester, with a watchdog that aborts hung transactions.

Parameters:
WIDTH, 24, frame width in bits; must equal master WIDTH
NREQ, 4, number of requesters, 2..8
TO_W, 8, watchdog counter width; timeout = 2^TO_W - 1 sclk cycles
READ_BIT, 23, command bit that marks a read frame (1 = read)

Ports:
n_rst  in  1  reset, asynchronous, active-low
sclk  in  1  clock; all logic on posedge sclk
req_valid  in  NREQ  per-requester request pending
req_data  in  NREQ*WIDTH  packed commands; requester i at [i*WIDTH +: WIDTH]
req_ready  out  NREQ  one-hot, one-cycle accept pulse
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  3  index of the requester owning the response
rsp_data  out  WIDTH  captured shift-in word (zero for write frames)
rsp_err  out  1  with rsp_valid: transaction aborted by watchdog
spi_in_data  out  WIDTH  to master in_data
spi_in_ena  out  1  to master in_ena
spi_busy  in  1  from master busy
spi_miso_reg  in  WIDTH  from master miso_reg
spi_miso_reg_ena  in  1  from master miso_reg_ena (end-of-frame pulse)
active  out  1  high whenever state != IDLE

Behaviour:
- Reset values (async): state IDLE; req_ready 0; rsp_valid 0; rsp_id 0; rsp_data 0; rsp_err 0; spi_in_data 0; spi_in_ena 0; rr pointer 0 (last grant = NREQ-1); watchdog 0.
- States: IDLE -> LOAD -> XFER -> DRAIN -> IDLE. Any non-IDLE state can go to IDLE on timeout.
- IDLE, when any req_valid is high and spi_busy is 0:
  - grant g = first set index searching g = last+1, last+2, ... modulo NREQ.
  - req_ready[g] = 1 for exactly this cycle; latch req_data slice g into spi_in_data.
  - latch the read flag = req_data slice g bit READ_BIT; rsp_id <= g; watchdog cleared; go to LOAD.
  - if spi_busy is 1 in IDLE, no grant is made.
- LOAD: spi_in_ena = 1, held until spi_busy is sampled 1, then spi_in_ena drops to 0 next cycle and the state goes to XFER.
- XFER: wait for spi_miso_reg_ena = 1.
  - read frame: rsp_data <= spi_miso_reg.
  - write frame: rsp_data <= 0.
  - rsp_valid pulses 1 cycle (rsp_err = 0); go to DRAIN.
- DRAIN: wait for spi_busy = 0, which covers the master's inter-frame pause; then update last grant = g and go to IDLE.
- Throughput: at most one grant per IDLE visit. Back-to-back requests from all requesters are served in strict rotation. The same requester cannot be granted twice while another is waiting.
- Watchdog: counts in LOAD/XFER/DRAIN and clears on each state change. At all-ones: spi_in_ena <= 0; rsp_valid = 1 with rsp_err = 1 and rsp_data = 0 (suppressed if the timeout occurs in DRAIN, where the response was already sent); go to IDLE; last grant = g.
- Simultaneous events:
  - spi_miso_reg_ena and a timeout in the same cycle: the normal completion wins.
  - req_valid dropping after grant has no effect; the request is already latched.
- req_valid[i] is assumed held until req_ready[i]; a dropped request before grant is simply not served.
- Reset mid-transaction aborts immediately with no response; pointer returns to 0.

Optional Feature:
SPI_SEQ_FIXED_PRIO_EN: when defined, arbitration is fixed priority (lowest index wins) and the rr pointer is not implemented. When undefined, round-robin as above. All other behaviour is identical.

Test Plan:
- Reset with n_rst=0 mid-LOAD -> all outputs at reset values within the same cycle; spi_in_ena=0; no rsp_valid after release.
- Single write: req_valid[1], req_data[1]=24'h012345; master model returns busy, then eof pulse with miso 24'hABCDEF -> req_ready[1] 1 cycle; spi_in_data=24'h012345; rsp_valid with rsp_id=1, rsp_data=0, rsp_err=0.
- Single read: req_data[2]=24'h800000 (READ_BIT set); miso_reg=24'h0000A5 at eof -> rsp_id=2, rsp_data=24'h0000A5.
- All four requesters valid continuously -> grant order 0,1,2,3,0,1; no grant while spi_busy=1; exactly one rsp per grant. With SPI_SEQ_FIXED_PRIO_EN, requester 0 is granted every time.
- Master model never asserts busy, TO_W=4 -> after 15 cycles in LOAD: rsp_valid with rsp_err=1, rsp_data=0; spi_in_ena=0; state returns to IDLE; next grant goes to the next requester.
- eof pulse and watchdog expiry in the same cycle -> rsp_err=0, captured data returned, state goes to DRAIN.
